exp4_unidade_controle: RTL and testbench

Moore-type control unit for the exp4 memory-check game. It sits directly upstream of exp4_fluxo_dados and drives that block's zeraC, contaC, zeraR and registraR inputs. It consumes chavesIgualMemoria and fimC back from the datapath. It sequences one switch entry per ROM address, compares the entry against the ROM word, advances the address, and stops in a success or failure state.

---
 rtl/exp4_unidade_controle.sv | 103 ++++++++++
 tb/tb_exp4_unidade_controle.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp4_unidade_controle.sv
// ============================================================================
// Module  : exp4_unidade_controle
// Purpose : Moore control FSM for the exp4 memory-check game
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module exp4_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'b0000,
    PREPARACAO  = 4'b0001,
    ESPERA      = 4'b0010,
    REGISTRA    = 4'b0100,
    COMPARACAO  = 4'b0101,
    PROXIMO     = 4'b0110,
    FIM_ACERTOU = 4'b1010,
    FIM_ERROU   = 4'b1110
  } estado_t;

  estado_t state_q, state_d;
  logic    jogada_ant_q;
  logic    w_jogada_borda;

  assign w_jogada_borda = jogada & ~jogada_ant_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= INICIAL;
      jogada_ant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      jogada_ant_q <= jogada;
    end
  end

  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL:     state_d = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  state_d = ESPERA;
      ESPERA:      state_d = w_jogada_borda ? REGISTRA : ESPERA;
      REGISTRA:    state_d = COMPARACAO;
      // A mismatch wins over end-of-memory.
      COMPARACAO: begin
        if (!igual)     state_d = FIM_ERROU;
        else if (fimC)  state_d = FIM_ACERTOU;
        else            state_d = PROXIMO;
      end
      PROXIMO:     state_d = ESPERA;
      FIM_ACERTOU: state_d = iniciar ? PREPARACAO : FIM_ACERTOU;
      FIM_ERROU:   state_d = iniciar ? PREPARACAO : FIM_ERROU;
      default:     state_d = INICIAL;
    endcase
  end

  always_comb begin
    zeraC     = 1'b0;
    contaC    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    case (state_q)
      PREPARACAO: begin
        zeraC = 1'b1;
        zeraR = 1'b1;
      end
      REGISTRA:    registraR = 1'b1;
      PROXIMO:     contaC    = 1'b1;
      FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state_q;

endmodule

`default_nettype wire

// File: tb/tb_exp4_unidade_controle.sv
// ============================================================================
// Module  : tb_exp4_unidade_controle
// Purpose : self-checking bench for the exp4 control unit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exp4_unidade_controle;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada, igual, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
  logic [3:0] db_estado;

  int n_tests = 0;
  int n_fail  = 0;

  exp4_unidade_controle dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
    .acertou(acertou), .errou(errou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Reference model: named game phases, outputs looked up per phase.
  typedef enum int {P_IDLE, P_PREP, P_WAIT, P_LOAD, P_CMP, P_NEXT, P_WIN, P_LOSE, P_BAD} phase_t;
  phase_t m_phase = P_IDLE;
  bit     m_prev  = 1'b0;
  bit     started = 1'b0;

  function automatic logic [3:0] phase_code(phase_t p);
    case (p)
      P_PREP: return 4'd1;
      P_WAIT: return 4'd2;
      P_LOAD: return 4'd4;
      P_CMP:  return 4'd5;
      P_NEXT: return 4'd6;
      P_WIN:  return 4'd10;
      P_LOSE: return 4'd14;
      default: return 4'd0;
    endcase
  endfunction

  // {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_estado}
  function automatic logic [10:0] expected(phase_t p);
    logic [6:0] o;
    o = 7'b0;
    if (p == P_PREP) o = 7'b1010000;
    if (p == P_NEXT) o = 7'b0100000;
    if (p == P_LOAD) o = 7'b0001000;
    if (p == P_WIN)  o = 7'b0000110;
    if (p == P_LOSE) o = 7'b0000101;
    return {o, phase_code(p)};
  endfunction

  always @(posedge clock) begin
    started <= 1'b1;
    if (reset) begin
      m_phase <= P_IDLE;
      m_prev  <= 1'b0;
    end else begin
      m_prev <= jogada;
      case (m_phase)
        P_IDLE:  m_phase <= iniciar ? P_PREP : P_IDLE;
        P_PREP:  m_phase <= P_WAIT;
        P_WAIT:  m_phase <= (jogada && !m_prev) ? P_LOAD : P_WAIT;
        P_LOAD:  m_phase <= P_CMP;
        P_CMP:   m_phase <= !igual ? P_LOSE : (fimC ? P_WIN : P_NEXT);
        P_NEXT:  m_phase <= P_WAIT;
        P_WIN, P_LOSE: if (iniciar) m_phase <= P_PREP;
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  int cnt_conta = 0;
  int cnt_reg   = 0;
  int cnt_zera  = 0;

  always @(negedge clock) begin
    logic [10:0] act, exp_v;
    if (started) begin
      act   = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, db_estado};
      exp_v = expected(m_phase);
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_compare t=%0t actual=%b required=%b", $time, act, exp_v);
      end
      if (contaC === 1'b1)    cnt_conta++;
      if (registraR === 1'b1) cnt_reg++;
      if (zeraC === 1'b1)     cnt_zera++;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // One entry starting in espera; leaves the FSM in espera or a final state.
  task automatic entry(input bit last, input bit match);
    igual  = match;
    fimC   = last;
    jogada = 1'b1;
    tick(1);           // registra
    jogada = 1'b0;
    tick(2);           // comparacao, then decision
    if (!last && match) tick(1);  // proximo -> espera
    fimC  = 1'b0;
    igual = 1'b1;
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
  endtask

  int base_c, base_r, base_z;

  initial begin
    reset = 1'b1; iniciar = 1'b1; jogada = 1'b1; igual = 1'b1; fimC = 1'b0;
    tick(2);
    check("reset_state", db_estado, 0);
    check("reset_pronto", pronto, 0);

    base_z = cnt_zera;
    reset = 1'b0;
    tick(1);
    check("prep_state", db_estado, 1);
    check("prep_zeraR", zeraR, 1);
    iniciar = 1'b0;
    tick(1);
    check("espera_state", db_estado, 2);
    check("zeraC_once", cnt_zera - base_z, 1);
    tick(3);                     // jogada held high since before espera: no entry
    check("no_entry_held", db_estado, 2);

    jogada = 1'b0;
    tick(2);
    base_c = cnt_conta; base_r = cnt_reg;
    jogada = 1'b1;
    tick(1);
    check("registra_state", db_estado, 4);
    tick(1);
    check("comparacao_state", db_estado, 5);
    tick(1);
    check("proximo_state", db_estado, 6);
    tick(7);                     // jogada held 10 cycles total
    check("held_one_load", cnt_reg - base_r, 1);
    check("held_one_count", cnt_conta - base_c, 1);
    check("held_parked", db_estado, 2);
    jogada = 1'b0;
    tick(1);

    entry(1'b0, 1'b0);
    check("errou_state", db_estado, 14);
    tick(20);
    check("errou_hold", errou, 1);
    check("errou_acertou", acertou, 0);
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    check("restart_prep", db_estado, 1);
    check("restart_errou_low", errou, 0);
    tick(1);

    entry(1'b1, 1'b0);
    check("mismatch_wins", db_estado, 14);

    start_game();
    base_c = cnt_conta;
    for (int i = 0; i < 16; i++) entry(i == 15, 1'b1);
    check("win_count15", cnt_conta - base_c, 15);
    check("win_state", db_estado, 10);
    check("win_acertou", acertou, 1);

    start_game();
    jogada = 1'b1;
    tick(1);
    check("mid_registra", db_estado, 4);
    reset = 1'b1;
    tick(1);
    check("reset_mid_state", db_estado, 0);
    check("reset_mid_reg", registraR, 0);
    reset = 1'b0; jogada = 1'b0;
    tick(1);

    start_game();
    for (int i = 0; i < 16; i++) entry(i == 15, 1'b1);
    check("win2_state", db_estado, 10);
    reset = 1'b1;
    tick(1);
    check("reset_win_state", db_estado, 0);
    check("reset_win_pronto", pronto, 0);
    reset = 1'b0;
    tick(2);
    check("idle_stays", db_estado, 0);
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    check("restart_after_reset", db_estado, 1);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
